// File: rtl/mem_stage_lsu.sv
// M-stage load/store unit: valid/grant/rvalid doubleword bus master.
// Ports: EX|M request in, stall/done/err/rdata to pipeline, mem_* bus.
module mem_stage_lsu #(
  parameter int ADDR_W = 64
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              req_valid,
  input  logic              req_read,
  input  logic              req_write,
  input  logic [2:0]        req_funct3,
  input  logic [ADDR_W-1:0] req_addr,
  input  logic [63:0]       req_wdata,
  output logic              stall,
  output logic              done,
  output logic [63:0]       rdata,
  output logic              err,
  output logic              mem_req,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [7:0]        mem_wstrb,
  output logic [63:0]       mem_wdata,
  input  logic              mem_gnt,
  input  logic              mem_rvalid,
  input  logic [63:0]       mem_rdata
);

  typedef enum logic [1:0] {
    IDLE, REQ, WAIT_R, DONE
  } state_t;

  state_t            state_q, state_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [2:0]        f3_q, f3_d;
  logic [63:0]       wdata_q, wdata_d;
  logic              we_q, we_d;
  logic              err_q, err_d;
  logic [63:0]       rdata_q, rdata_d;

  logic        req_in;
  logic        misal;
  logic        bad_in;
  logic [2:0]  lane;
  logic [63:0] sh;
  logic [63:0] fmt;

  assign req_in = req_valid & (req_read | req_write);
  assign lane   = addr_q[2:0];
  assign sh     = mem_rdata >> {lane, 3'b000};

  always_comb begin
    misal = 1'b0;
    case (req_funct3[1:0])
      2'b01:   misal = req_addr[0];
      2'b10:   misal = |req_addr[1:0];
      2'b11:   misal = |req_addr[2:0];
      default: misal = 1'b0;
    endcase
    bad_in = (req_read & req_write)
           | (req_funct3 == 3'b111)
           | (req_write & req_funct3[2])
           | misal;
  end

  always_comb begin
    fmt = 64'h0;
    case (f3_q)
      3'b000:  fmt = {{56{sh[7]}}, sh[7:0]};
      3'b001:  fmt = {{48{sh[15]}}, sh[15:0]};
      3'b010:  fmt = {{32{sh[31]}}, sh[31:0]};
      3'b011:  fmt = sh;
      3'b100:  fmt = {56'h0, sh[7:0]};
      3'b101:  fmt = {48'h0, sh[15:0]};
      3'b110:  fmt = {32'h0, sh[31:0]};
      default: fmt = 64'h0;
    endcase
  end

  always_comb begin
    state_d = state_q;
    addr_d  = addr_q;
    f3_d    = f3_q;
    wdata_d = wdata_q;
    we_d    = we_q;
    err_d   = err_q;
    rdata_d = rdata_q;
    unique case (state_q)
      IDLE: begin
        if (req_in) begin
          addr_d  = req_addr;
          f3_d    = req_funct3;
          wdata_d = req_wdata;
          we_d    = req_write;
          err_d   = bad_in;
          state_d = bad_in ? DONE : REQ;
        end
      end
      REQ: begin
        if (mem_gnt) state_d = we_q ? DONE : WAIT_R;
      end
      WAIT_R: begin
        if (mem_rvalid) begin
          rdata_d = fmt;
          state_d = DONE;
        end
      end
      DONE: begin
        err_d   = 1'b0;
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= IDLE;
      addr_q  <= '0;
      f3_q    <= '0;
      wdata_q <= '0;
      we_q    <= 1'b0;
      err_q   <= 1'b0;
      rdata_q <= '0;
    end else begin
      state_q <= state_d;
      addr_q  <= addr_d;
      f3_q    <= f3_d;
      wdata_q <= wdata_d;
      we_q    <= we_d;
      err_q   <= err_d;
      rdata_q <= rdata_d;
    end
  end

  // Reset gates stall so a held req_valid cannot freeze the pipe in reset.
  assign stall = rst & ((state_q == IDLE & req_in)
                      | state_q == REQ
                      | state_q == WAIT_R);
  assign done     = state_q == DONE;
  assign err      = done & err_q;
  assign rdata    = rdata_q;
  assign mem_req  = state_q == REQ;
  assign mem_we   = mem_req & we_q;
  assign mem_addr = {addr_q[ADDR_W-1:3], 3'b000};

  always_comb begin
    mem_wstrb = 8'h00;
    mem_wdata = 64'h0;
    if (mem_we) begin
      case (f3_q[1:0])
        2'b00: begin
          mem_wstrb = 8'h01 << lane;
          mem_wdata = {8{wdata_q[7:0]}};
        end
        2'b01: begin
          mem_wstrb = 8'h03 << lane;
          mem_wdata = {4{wdata_q[15:0]}};
        end
        2'b10: begin
          mem_wstrb = 8'h0F << lane;
          mem_wdata = {2{wdata_q[31:0]}};
        end
        default: begin
          mem_wstrb = 8'hFF;
          mem_wdata = wdata_q;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_mem_stage_lsu.sv
// Bench for mem_stage_lsu: directed ops, behavioural model, per-cycle compare.
// Literal checks pin timing and data from hand-worked cases.
module tb_mem_stage_lsu;

  logic        clk;
  logic        rst;
  logic        req_valid, req_read, req_write;
  logic [2:0]  req_funct3;
  logic [63:0] req_addr, req_wdata;
  logic        stall, done, err;
  logic [63:0] rdata;
  logic        mem_req, mem_we;
  logic [63:0] mem_addr;
  logic [7:0]  mem_wstrb;
  logic [63:0] mem_wdata;
  logic        mem_gnt, mem_rvalid;
  logic [63:0] mem_rdata;

  mem_stage_lsu #(.ADDR_W(64)) dut (
    .clk(clk), .rst(rst),
    .req_valid(req_valid), .req_read(req_read),
    .req_write(req_write), .req_funct3(req_funct3),
    .req_addr(req_addr), .req_wdata(req_wdata),
    .stall(stall), .done(done), .rdata(rdata), .err(err),
    .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr),
    .mem_wstrb(mem_wstrb), .mem_wdata(mem_wdata),
    .mem_gnt(mem_gnt), .mem_rvalid(mem_rvalid),
    .mem_rdata(mem_rdata)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  logic        e_stall, e_done, e_err, e_mreq, e_we;
  logic [63:0] e_addr, e_wd, exp_rdata;
  logic [7:0]  e_strb;

  int cyc, st_cnt, done_cyc, req_cnt;
  logic [63:0] snap_addr, snap_wd;
  logic [7:0]  snap_strb;

  task automatic chk(input string n, input logic [63:0] act,
                     input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s got %h want %h", n, act, exp);
    end
  endtask

  function automatic bit m_bad(input bit rd, input bit wr,
                               input logic [2:0] f3,
                               input logic [63:0] a);
    int sz;
    if (rd && wr) return 1'b1;
    if (f3 == 3'd7) return 1'b1;
    if (wr && f3 > 3'd3) return 1'b1;
    sz = 1 << f3[1:0];
    return (int'(a[2:0]) % sz) != 0;
  endfunction

  function automatic logic [7:0] m_strb(input logic [2:0] f3,
                                        input logic [63:0] a);
    int sz, ln;
    logic [7:0] s;
    sz = 1 << f3[1:0];
    ln = int'(a[2:0]);
    s = 8'h00;
    for (int i = 0; i < 8; i++)
      if (i >= ln && i < ln + sz) s[i] = 1'b1;
    return s;
  endfunction

  function automatic logic [63:0] m_wdata(input logic [2:0] f3,
                                          input logic [63:0] w);
    int sz;
    logic [63:0] v;
    sz = 1 << f3[1:0];
    v = 64'h0;
    for (int i = 0; i < 8; i++) v[8*i +: 8] = w[8*(i % sz) +: 8];
    return v;
  endfunction

  function automatic logic [63:0] m_load(input logic [2:0] f3,
                                         input logic [63:0] a,
                                         input logic [63:0] d);
    int sz, ln;
    logic [63:0] v;
    sz = 1 << f3[1:0];
    ln = int'(a[2:0]);
    v = 64'h0;
    for (int i = 0; i < sz; i++) v[8*i +: 8] = d[8*(ln+i) +: 8];
    if (f3 < 3'd3 && v[8*sz-1])
      for (int i = sz; i < 8; i++) v[8*i +: 8] = 8'hFF;
    return v;
  endfunction

  always @(negedge clk) begin
    chk("stall", {63'h0, stall}, {63'h0, e_stall});
    chk("done", {63'h0, done}, {63'h0, e_done});
    chk("err", {63'h0, err}, {63'h0, e_err});
    chk("mem_req", {63'h0, mem_req}, {63'h0, e_mreq});
    chk("rdata", rdata, exp_rdata);
    if (e_mreq) begin
      chk("mem_addr", mem_addr, e_addr);
      chk("mem_we", {63'h0, mem_we}, {63'h0, e_we});
      if (e_we) begin
        chk("mem_wstrb", {56'h0, mem_wstrb}, {56'h0, e_strb});
        chk("mem_wdata", mem_wdata, e_wd);
      end
    end
    if (mem_req) begin
      snap_addr = mem_addr;
      snap_strb = mem_wstrb;
      snap_wd   = mem_wdata;
      req_cnt++;
    end
    cyc++;
    if (stall) st_cnt++;
    if (done && done_cyc == 0) done_cyc = cyc;
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic clr_stats();
    cyc = 0;
    st_cnt = 0;
    done_cyc = 0;
    req_cnt = 0;
  endtask

  // g: extra REQ cycles before gnt; r: WAIT_R cycles before rvalid.
  task automatic op(input bit rd, input bit wr, input logic [2:0] f3,
                    input logic [63:0] a, input logic [63:0] wd,
                    input int g, input int r, input bit rv_early,
                    input logic [63:0] md);
    bit b;
    b = m_bad(rd, wr, f3, a);
    clr_stats();
    req_valid = 1'b1;
    req_read = rd;
    req_write = wr;
    req_funct3 = f3;
    req_addr = a;
    req_wdata = wd;
    e_stall = 1'b1;
    e_done = 1'b0;
    e_err = 1'b0;
    e_mreq = 1'b0;
    tick();
    if (!b) begin
      for (int k = 0; k <= g; k++) begin
        e_mreq = 1'b1;
        e_we = wr;
        e_addr = {a[63:3], 3'b000};
        e_strb = m_strb(f3, a);
        e_wd = m_wdata(f3, wd);
        mem_gnt = (k == g);
        mem_rvalid = (k == g) && rv_early;
        mem_rdata = md;
        tick();
      end
      mem_gnt = 1'b0;
      mem_rvalid = 1'b0;
      e_mreq = 1'b0;
      if (rd) begin
        for (int j = 0; j <= r; j++) begin
          mem_rvalid = (j == r);
          mem_rdata = md;
          tick();
        end
        mem_rvalid = 1'b0;
        exp_rdata = m_load(f3, a, md);
      end
    end
    e_stall = 1'b0;
    e_done = 1'b1;
    e_err = b;
    tick();
    req_valid = 1'b0;
    req_read = 1'b0;
    req_write = 1'b0;
    e_done = 1'b0;
    e_err = 1'b0;
    tick();
  endtask

  initial begin
    rst = 1'b0;
    req_valid = 1'b1;
    req_read = 1'b1;
    req_write = 1'b0;
    req_funct3 = 3'd3;
    req_addr = 64'h0;
    req_wdata = 64'h0;
    mem_gnt = 1'b0;
    mem_rvalid = 1'b0;
    mem_rdata = 64'h0;
    e_stall = 1'b0;
    e_done = 1'b0;
    e_err = 1'b0;
    e_mreq = 1'b0;
    e_we = 1'b0;
    e_addr = 64'h0;
    e_wd = 64'h0;
    e_strb = 8'h0;
    exp_rdata = 64'h0;
    snap_addr = 64'h0;
    snap_wd = 64'h0;
    snap_strb = 8'h0;
    clr_stats();
    #3;
    chk("rst_stall", {63'h0, stall}, 64'h0);
    chk("rst_rdata", rdata, 64'h0);
    chk("rst_mem_req", {63'h0, mem_req}, 64'h0);
    tick();
    rst = 1'b1;
    req_valid = 1'b0;
    req_read = 1'b0;
    tick();

    op(0, 1, 3'd3, 64'h1008, 64'h1122334455667788, 1, 0, 0, 64'h0);
    chk("sd_addr", snap_addr, 64'h1008);
    chk("sd_strb", {56'h0, snap_strb}, 64'hFF);
    chk("sd_stall_cycles", 64'(st_cnt), 64'd3);
    chk("sd_done_cycle", 64'(done_cyc), 64'd4);

    op(1, 0, 3'd0, 64'h2003, 64'h0, 0, 0, 0, 64'h00000000_80000000);
    chk("lb_addr", snap_addr, 64'h2000);
    chk("lb_rdata", rdata, 64'hFFFFFFFFFFFFFF80);
    chk("lb_done_cycle", 64'(done_cyc), 64'd4);

    op(1, 0, 3'd4, 64'h2003, 64'h0, 0, 0, 0, 64'h00000000_80000000);
    chk("lbu_rdata", rdata, 64'h80);

    op(0, 1, 3'd1, 64'h0006, 64'hABCD, 0, 0, 0, 64'h0);
    chk("sh_strb", {56'h0, snap_strb}, 64'hC0);
    chk("sh_wdata_hi", {48'h0, snap_wd[63:48]}, 64'hABCD);
    chk("sh_done_cycle", 64'(done_cyc), 64'd3);

    op(1, 0, 3'd2, 64'h0002, 64'h0, 0, 0, 0, 64'h0);
    chk("lw_mis_nobus", 64'(req_cnt), 64'd0);
    chk("lw_mis_done_cycle", 64'(done_cyc), 64'd2);
    chk("lw_mis_rdata", rdata, 64'h80);

    op(1, 1, 3'd3, 64'h0000, 64'h0, 0, 0, 0, 64'h0);
    chk("rdwr_nobus", 64'(req_cnt), 64'd0);
    chk("rdwr_stall_cycles", 64'(st_cnt), 64'd1);

    op(0, 1, 3'd4, 64'h0010, 64'h55, 0, 0, 0, 64'h0);
    op(1, 0, 3'd7, 64'h0010, 64'h0, 0, 0, 0, 64'h0);
    chk("bad_rdata", rdata, 64'h80);

    op(1, 0, 3'd6, 64'h0004, 64'h0, 0, 2, 1, 64'hF0000000_00000000);
    chk("lwu_rdata", rdata, 64'h00000000F0000000);
    chk("lwu_done_cycle", 64'(done_cyc), 64'd6);

    op(0, 1, 3'd2, 64'h3004, 64'hDEADBEEF, 0, 0, 0, 64'h0);
    chk("sw_strb", {56'h0, snap_strb}, 64'hF0);
    chk("sw_wdata", snap_wd, 64'hDEADBEEF_DEADBEEF);
    op(0, 1, 3'd0, 64'h3005, 64'h1A2, 2, 0, 0, 64'h0);
    chk("sb_wdata", snap_wd, 64'hA2A2A2A2_A2A2A2A2);
    op(1, 0, 3'd1, 64'h0006, 64'h0, 1, 1, 0, 64'h8001_0000_0000_0000);
    chk("lh_rdata", rdata, 64'hFFFFFFFFFFFF8001);

    clr_stats();
    req_valid = 1'b1;
    req_read = 1'b1;
    req_write = 1'b0;
    req_funct3 = 3'd3;
    req_addr = 64'h40;
    e_stall = 1'b1;
    e_mreq = 1'b0;
    tick();
    e_mreq = 1'b1;
    e_we = 1'b0;
    e_addr = 64'h40;
    mem_gnt = 1'b1;
    tick();
    mem_gnt = 1'b0;
    e_mreq = 1'b0;
    #1;
    rst = 1'b0;
    exp_rdata = 64'h0;
    e_stall = 1'b0;
    #1;
    chk("rst_mid_req", {63'h0, mem_req}, 64'h0);
    chk("rst_mid_stall", {63'h0, stall}, 64'h0);
    chk("rst_mid_done", {63'h0, done}, 64'h0);
    tick();
    rst = 1'b1;
    req_valid = 1'b0;
    req_read = 1'b0;
    mem_rvalid = 1'b1;
    mem_rdata = 64'hFFFF_FFFF_FFFF_FFFF;
    tick();
    mem_rvalid = 1'b0;
    tick();
    chk("rst_late_rvalid", rdata, 64'h0);

    op(1, 0, 3'd3, 64'h3000, 64'h0, 2, 1, 0, 64'h0123456789ABCDEF);
    chk("ld_after_rst", rdata, 64'h0123456789ABCDEF);
    chk("ld_done_cycle", 64'(done_cyc), 64'd7);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
